// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter
// Shares the write port of a single write-enabled register between NUM_REQ
// requesters. Arbitration is round-robin. A requester that asserts lock_in
// when it wins keeps the port for back-to-back writes, for at most MAX_LOCK
// consecutive cycles. All outputs are registered and drive the register's
// write-enable and data inputs directly.
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   req_in      per-requester write request (level)
//   lock_in     per-requester request to keep ownership after grant
//   data_in     packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt_out     one-hot grant pulse (registered)
//   r_en_out    register write enable (registered)
//   r_data_out  register write data (registered, holds when idle)
//   busy_out    high while a requester holds the lock
//   owner_out   index of the last granted requester
module reg_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [NUM_REQ-1:0]         lock_in,
  input  logic [NUM_REQ*DATA_W-1:0]  data_in,
  output logic [NUM_REQ-1:0]         gnt_out,
  output logic                       r_en_out,
  output logic [DATA_W-1:0]          r_data_out,
  output logic                       busy_out,
  output logic [$clog2(NUM_REQ)-1:0] owner_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  // With MAX_LOCK == 1 the single winning grant already uses the whole
  // allowance, so the LOCKED state is never entered.
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                   state_r, state_s;
  logic [CNT_W-1:0]         lock_cnt_r, lock_cnt_s, lock_cnt_inc_s;
  logic [NUM_REQ-1:0]       cand_s;
  logic [IDX_W-1:0]         win_s;
  logic [NUM_REQ-1:0]       gnt_s;
  logic                     r_en_s;
  logic [DATA_W-1:0]        r_data_s;
  logic [IDX_W-1:0]         owner_s;

  // Round-robin pick: first set bit of cand searching last+1, last+2, ...
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] cand,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (cand[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  // Extract one requester's data word from the packed bus.
  function automatic logic [DATA_W-1:0] data_of(
    input logic [NUM_REQ*DATA_W-1:0] d,
    input logic [IDX_W-1:0]          sel
  );
    logic [DATA_W-1:0] v;
    v = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        v = d[i*DATA_W +: DATA_W];
      end
    end
    return v;
  endfunction

  // Next-state, lock counter and next output values.
  always_comb begin
    state_s        = state_r;
    lock_cnt_s     = lock_cnt_r;
    lock_cnt_inc_s = lock_cnt_r + CNT_W'(1);
    owner_s        = owner_out;
    gnt_s          = {NUM_REQ{1'b0}};
    r_en_s         = 1'b0;
    r_data_s       = r_data_out;
    // Mask the requester currently being granted: it may still show req
    // for this cycle while it drops it, and must not win twice.
    cand_s         = req_in & ~gnt_out;
    win_s          = rr_pick(cand_s, owner_out);

    case (state_r)
      IDLE: begin
        if (|cand_s) begin
          gnt_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
          r_en_s   = 1'b1;
          r_data_s = data_of(data_in, win_s);
          owner_s  = win_s;
          if (lock_in[win_s] && LOCK_EN) begin
            state_s    = LOCKED;
            lock_cnt_s = CNT_W'(1);
          end else begin
            state_s    = IDLE;
            lock_cnt_s = {CNT_W{1'b0}};
          end
        end else begin
          state_s    = IDLE;
          lock_cnt_s = {CNT_W{1'b0}};
        end
      end

      LOCKED: begin
        // The owner streams; its req is deliberately not masked here.
        if (req_in[owner_out]) begin
          gnt_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_out;
          r_en_s   = 1'b1;
          r_data_s = data_of(data_in, owner_out);
        end else begin
          gnt_s    = {NUM_REQ{1'b0}};
          r_en_s   = 1'b0;
        end
        // Idle locked cycles count too. The grant decided in the exit
        // cycle still issues; owner stays the rr pointer so it gets the
        // lowest priority in the next arbitration.
        if (!lock_in[owner_out] || (lock_cnt_inc_s >= CNT_W'(MAX_LOCK))) begin
          state_s    = IDLE;
          lock_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s    = LOCKED;
          lock_cnt_s = lock_cnt_inc_s;
        end
      end

      default: begin
        state_s    = IDLE;
        lock_cnt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any pending write.
  // owner_out doubles as the round-robin pointer (last granted index).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      lock_cnt_r <= {CNT_W{1'b0}};
      gnt_out    <= {NUM_REQ{1'b0}};
      r_en_out   <= 1'b0;
      r_data_out <= {DATA_W{1'b0}};
      busy_out   <= 1'b0;
      owner_out  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_r    <= state_s;
      lock_cnt_r <= lock_cnt_s;
      gnt_out    <= gnt_s;
      r_en_out   <= r_en_s;
      r_data_out <= r_data_s;
      busy_out   <= (state_s == LOCKED);
      owner_out  <= owner_s;
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench for reg_wr_arbiter: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_reg_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int ML = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req   = '0;
  logic [N-1:0]     lock  = '0;
  logic [N*W-1:0]   data  = '0;
  logic [N-1:0]     gnt_out;
  logic             r_en_out;
  logic [W-1:0]     r_data_out;
  logic             busy_out;
  logic [1:0]       owner_out;

  int tests = 0;
  int fails = 0;

  // Behavioural model: granted index (-1 = none), owner, lock status and
  // number of cycles the current lock has been held.
  int          m_gnt    = -1;
  int          m_owner  = N - 1;
  bit          m_locked = 1'b0;
  int          m_held   = 0;
  logic [W-1:0] m_data  = '0;

  reg_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_LOCK(ML)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_in     (req),
    .lock_in    (lock),
    .data_in    (data),
    .gnt_out    (gnt_out),
    .r_en_out   (r_en_out),
    .r_data_out (r_data_out),
    .busy_out   (busy_out),
    .owner_out  (owner_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    return data[i*W +: W];
  endfunction

  task automatic set_data(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  // Apply the arbitration rules to the inputs seen at this clock edge.
  task automatic model_step();
    int win;
    int c;
    if (reset) begin
      m_gnt    = -1;
      m_data   = '0;
      m_owner  = N - 1;
      m_locked = 1'b0;
      m_held   = 0;
    end else if (!m_locked) begin
      win = -1;
      for (int off = 1; off <= N; off++) begin
        c = (m_owner + off) % N;
        if (win < 0 && req[c] && c != m_gnt) win = c;
      end
      m_gnt = win;
      if (win >= 0) begin
        m_data  = word(win);
        m_owner = win;
        if (lock[win] && ML > 1) begin
          m_locked = 1'b1;
          m_held   = 1;
        end
      end
    end else begin
      m_held++;
      m_gnt = req[m_owner] ? m_owner : -1;
      if (m_gnt >= 0) m_data = word(m_owner);
      if (!lock[m_owner] || m_held >= ML) m_locked = 1'b0;
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_gnt >= 0) g[m_gnt] = 1'b1;
    return g;
  endfunction

  // One clock: update the model at the edge, compare just after it.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("gnt",    32'(gnt_out),    32'(exp_gnt()));
    check("r_en",   32'(r_en_out),   32'(m_gnt >= 0));
    check("r_data", 32'(r_data_out), 32'(m_data));
    check("busy",   32'(busy_out),   32'(m_locked));
    check("owner",  32'(owner_out),  32'(m_owner));
    check("onehot", 32'($onehot0(gnt_out)), 32'd1);
    check("en_gnt", 32'(r_en_out), 32'(|gnt_out));
  endtask

  logic [N-1:0] rot [5];

  initial begin
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100;
    rot[3] = 4'b1000; rot[4] = 4'b0001;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_gnt",   32'(gnt_out),    32'h0);
    check("rst_ren",   32'(r_en_out),   32'h0);
    check("rst_data",  32'(r_data_out), 32'h0);
    check("rst_busy",  32'(busy_out),   32'h0);
    check("rst_owner", 32'(owner_out),  32'h3);
    reset = 1'b0;

    // Two requesters, requester 0 first, then 2
    req = 4'b0101;
    set_data(0, 16'hAAAA);
    set_data(2, 16'h5555);
    tick();
    check("s1_gnt0",  32'(gnt_out),    32'h1);
    check("s1_data0", 32'(r_data_out), 32'hAAAA);
    req = 4'b0100;
    tick();
    check("s1_gnt2",  32'(gnt_out),    32'h4);
    check("s1_data2", 32'(r_data_out), 32'h5555);
    req = 4'b0000;
    tick();
    check("s1_idle", 32'(r_en_out), 32'h0);
    check("s1_hold", 32'(r_data_out), 32'h5555);

    // All four requesting: strict rotation from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2_rot", 32'(gnt_out), 32'(rot[i]));
    end
    req = 4'b0000;
    tick();

    // Requester 1 locks and streams; requester 3 waits
    req  = 4'b1010;
    lock = 4'b0010;
    set_data(1, 16'h0001);
    set_data(3, 16'h3333);
    for (int i = 1; i <= 4; i++) begin
      set_data(1, 16'(i));
      tick();
      check("s3_gnt1",  32'(gnt_out),    32'h2);
      check("s3_data1", 32'(r_data_out), 32'(i));
      check("s3_busy",  32'(busy_out),   32'(i < 4));
    end
    tick();
    check("s3_gnt3",  32'(gnt_out),    32'h8);
    check("s3_data3", 32'(r_data_out), 32'h3333);
    req  = 4'b0000;
    lock = 4'b0000;
    tick();

    // Requester 2 locks, releases after two grants; requester 0 pending
    req  = 4'b0100;
    lock = 4'b0100;
    set_data(2, 16'h2222);
    set_data(0, 16'h0F0F);
    tick();
    check("s4_gnt2a", 32'(gnt_out), 32'h4);
    check("s4_busy",  32'(busy_out), 32'h1);
    req = 4'b0101;
    tick();
    check("s4_gnt2b", 32'(gnt_out), 32'h4);
    req  = 4'b0001;
    lock = 4'b0000;
    tick();
    check("s4_no3rd", 32'(gnt_out),  32'h0);
    check("s4_idle",  32'(busy_out), 32'h0);
    tick();
    check("s4_gnt0",  32'(gnt_out),    32'h1);
    check("s4_data0", 32'(r_data_out), 32'h0F0F);
    req = 4'b0000;
    tick();

    // Reset while locked with a grant pending
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    check("s5_locked", 32'(busy_out), 32'h1);
    reset = 1'b1;
    tick();
    check("s5_gnt",   32'(gnt_out),    32'h0);
    check("s5_ren",   32'(r_en_out),   32'h0);
    check("s5_data",  32'(r_data_out), 32'h0);
    check("s5_busy",  32'(busy_out),   32'h0);
    check("s5_owner", 32'(owner_out),  32'h3);
    reset = 1'b0;
    req   = 4'b0000;
    lock  = 4'b0000;
    tick();
    check("s5_after", 32'(r_en_out), 32'h0);

    // Requester 3 pulses req while requester 0 owns the port
    req  = 4'b0001;
    lock = 4'b0001;
    tick();
    req = 4'b1001;
    tick();
    check("s6_no3a", 32'(gnt_out[3]), 32'h0);
    req = 4'b0001;
    tick();
    check("s6_no3b", 32'(gnt_out[3]), 32'h0);
    req  = 4'b0000;
    lock = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s6_no3c", 32'(gnt_out[3]), 32'h0);
    end

    // Randomized traffic, occasional reset
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      req   = 4'($urandom);
      lock  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      data  = {$urandom, $urandom};
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
